// File: rtl/sync_fifo_fwft_pkg.sv
// sync_fifo_fwft_pkg: shared depth derivation for the FWFT FIFO
package sync_fifo_fwft_pkg;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft_ram.sv
// sync_fifo_fwft_ram: DEPTH x WIDTH storage, one sync write port, one async read port
module sync_fifo_fwft_ram import sync_fifo_fwft_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [fifo_depth(ADDR_W)];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO with count, thresholds, flush and sticky error flags
module sync_fifo_fwft import sync_fifo_fwft_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int AFULL_LVL  = fifo_depth(ADDR_W) - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W+1)'(AEMPTY_LVL);
  if (AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("AFULL_LVL exceeds DEPTH");
  end
  if (AEMPTY_LVL >= DEPTH) begin : g_bad_aempty
    $error("AEMPTY_LVL must be below DEPTH");
  end
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop, clr;
  assign clr          = rst || flush;
  assign empty        = count == '0;
  assign full         = count == FULL_CNT;
  assign almost_full  = count >= AF_CNT;
  assign almost_empty = count <= AE_CNT;
  assign do_pop       = rd_en && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push      = wr_en && (!full || do_pop);
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
      if (wr_en && !do_push) overflow <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
  sync_fifo_fwft_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (do_push && !clr),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed and random scenarios against a queue scoreboard
module tb_sync_fifo_fwft;
  logic       clk = 0;
  logic       rst = 0;
  logic       flush = 0;
  logic       wr_en = 0;
  logic [7:0] wr_data = 0;
  logic       rd_en = 0;
  logic [7:0] rd_data;
  logic       empty, full, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit m_ovf, m_unf;

  sync_fifo_fwft dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) assert (!$isunknown({wr_en, rd_en}));

  // drive one clock of stimulus and advance the scoreboard by what the FIFO should accept
  task automatic cycle(input bit we, input logic [7:0] wd, input bit re,
                       input bit fl = 0, input bit rs = 0);
    bit dpop, dpush;
    wr_en = we; wr_data = wd; rd_en = re; flush = fl; rst = rs;
    dpop  = re && q.size() > 0;
    dpush = we && (q.size() < 8 || dpop);
    @(posedge clk);
    #1;
    if (rs || fl) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (re && q.size() == 0) m_unf = 1;
      if (we && !dpush) m_ovf = 1;
      if (dpop) void'(q.pop_front());
      if (dpush) q.push_back(wd);
    end
    wr_en = 0; rd_en = 0; flush = 0; rst = 0;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 1);
    checks++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      errors++;
      $display("FAIL reset_flags got %b want 101000", {empty, full, almost_empty, almost_full, overflow, underflow});
    end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'(8'h10 + i), 0);
      checks++;
      if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 7) || full !== (i == 7)) begin
        errors++;
        $display("FAIL fill_%0d got count=%0d af=%b full=%b want count=%0d af=%b full=%b",
                 i, count, almost_full, full, i + 1, i + 1 >= 7, i == 7);
      end
    end
    cycle(1, 8'h18, 0);
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++; $display("FAIL fill_overflow got ovf=%b count=%0d want 1 8", overflow, count);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data !== 8'(8'h10 + i) || q[0] !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL fill_pop_%0d got %h want %h", i, rd_data, 8'(8'h10 + i));
      end
      cycle(0, 0, 1);
    end
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL fill_drained got empty=%b count=%0d want 1 0", empty, count);
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (q.size() == 0 || rd_data !== q[0]) begin
        errors++; $display("FAIL wrap_data_%0d got %h want %h", i, rd_data, q.size() ? q[0] : 8'h00);
      end
      cycle(1, 8'(8'h30 + i), 1);
      checks++;
      if (count !== 4'd3) begin errors++; $display("FAIL wrap_count_%0d got %0d want 3", i, count); end
    end
    checks++;
    if (rd_data !== 8'h41) begin errors++; $display("FAIL wrap_head got %h want 41", rd_data); end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h40 + i), 0);
    cycle(1, 8'hAA, 1);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || rd_data !== 8'h41) begin
      errors++; $display("FAIL full_pushpop got count=%0d ovf=%b head=%h want 8 0 41", count, overflow, rd_data);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data !== (i == 7 ? 8'hAA : 8'(8'h41 + i))) begin
        errors++; $display("FAIL full_drain_%0d got %h want %h", i, rd_data, i == 7 ? 8'hAA : 8'(8'h41 + i));
      end
      cycle(0, 0, 1);
    end
  endtask

  task automatic test_empty_pushpop();
    cycle(1, 8'h55, 1);
    checks++;
    if (underflow !== 1'b1 || count !== 4'd1 || rd_data !== 8'h55) begin
      errors++; $display("FAIL empty_pushpop got unf=%b count=%0d data=%h want 1 1 55", underflow, count, rd_data);
    end
    cycle(0, 0, 1);
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_flush();
    cycle(0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h60 + i), 0);
    checks++;
    if (count !== 4'd5 || underflow !== 1'b1) begin
      errors++; $display("FAIL flush_pre got count=%0d unf=%b want 5 1", count, underflow);
    end
    cycle(1, 8'h77, 0, 1);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL flush got count=%0d empty=%b ovf=%b unf=%b want 0 1 0 0", count, empty, overflow, underflow);
    end
    cycle(1, 8'h99, 0);
    checks++;
    if (rd_data !== 8'h99 || count !== 4'd1) begin
      errors++; $display("FAIL flush_after got %h count=%0d want 99 1", rd_data, count);
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h80 + i), 0);
    cycle(1, 8'h88, 0);
    cycle(1, 8'h89, 1, 0, 1);
    checks++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000 || count !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid got %b count=%0d want 101000 0", {empty, full, almost_empty, almost_full, overflow, underflow}, count);
    end
  endtask

  task automatic test_fwft();
    cycle(1, 8'h3C, 0);
    checks++;
    if (empty !== 1'b0 || rd_data !== 8'h3C) begin
      errors++; $display("FAIL fwft got empty=%b data=%h want 0 3c", empty, rd_data);
    end
    cycle(0, 0, 1);
  endtask

  task automatic test_random();
    int pw;
    for (int i = 0; i < 10000; i++) begin
      pw = (i / 500) % 2 ? 70 : 30;
      if (q.size() > 0) begin
        checks++;
        if (rd_data !== q[0]) begin errors++; $display("FAIL rand_data_%0d got %h want %h", i, rd_data, q[0]); end
      end
      cycle($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < 100 - pw, $urandom_range(999) == 0);
      checks++;
      if (count !== 4'(q.size()) ||
          {empty, full, almost_empty, almost_full, overflow, underflow} !==
          {q.size() == 0, q.size() == 8, q.size() <= 1, q.size() >= 7, m_ovf, m_unf}) begin
        errors++;
        $display("FAIL rand_state_%0d got count=%0d flags=%b want count=%0d flags=%b", i, count,
                 {empty, full, almost_empty, almost_full, overflow, underflow}, q.size(),
                 {q.size() == 0, q.size() == 8, q.size() <= 1, q.size() >= 7, m_ovf, m_unf});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_full_pushpop();
    test_empty_pushpop();
    test_flush();
    test_rst_mid();
    test_fwft();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
